// File: rtl/sync_hs_send.sv
`default_nettype none
// ============================================================================
// Module   : sync_hs_send
// Brief    : Source end of a two-phase toggle handshake for CDC word transfer.
//            Optional ack-timeout flag: define SYNC_HS_SEND_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module sync_hs_send #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             enq__ENA,
   input  logic [WIDTH-1:0] enq_v,
   output logic             enq__RDY,
   output logic             xfer_req,
   output logic [WIDTH-1:0] xfer_data,
   input  logic             xfer_ack,
   output logic             done,
   output logic             timeout
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ack_chain;
   logic                   ack_sync;
   logic                   accept;

   // Resynchronise the asynchronous ack toggle; oldest sample is the MSB.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ack_chain <= '0;
      end else begin
         ack_chain <= {ack_chain[SYNC_STAGES-2:0], xfer_ack};
      end
   end

   assign ack_sync = ack_chain[SYNC_STAGES-1];
   assign enq__RDY = (state == IDLE) && (ack_sync == xfer_req);
   assign accept   = enq__ENA && enq__RDY;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         xfer_req  <= 1'b0;
         xfer_data <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  xfer_data <= enq_v;
                  xfer_req  <= ~xfer_req;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (ack_sync == xfer_req) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SYNC_HS_SEND_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] cnt_next;

   assign cnt_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);

   // Flag is sticky until reset; the handshake itself keeps waiting.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else if (accept) begin
         wait_cnt <= '0;
      end else if (state == WAIT) begin
         wait_cnt <= cnt_next;
         if (cnt_next == CNT_MAX) begin
            timeout <= 1'b1;
         end
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_hs_send.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_hs_send
// Brief    : Self-checking bench for sync_hs_send with a toggle-protocol model.
// Revision : 1.0
// ============================================================================
module tb_sync_hs_send;

   localparam int WIDTH       = 32;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 16;
`ifdef SYNC_HS_SEND_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic             CLK;
   logic             nRST;
   logic             enq__ENA;
   logic [WIDTH-1:0] enq_v;
   logic             enq__RDY;
   logic             xfer_req;
   logic [WIDTH-1:0] xfer_data;
   logic             xfer_ack;
   logic             done;
   logic             timeout;

   sync_hs_send #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .enq__ENA (enq__ENA),
      .enq_v    (enq_v),
      .enq__RDY (enq__RDY),
      .xfer_req (xfer_req),
      .xfer_data(xfer_data),
      .xfer_ack (xfer_ack),
      .done     (done),
      .timeout  (timeout)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int vectors     = 0;
   int miscompares = 0;
   bit run         = 1'b0;
   int done_cnt    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Protocol model: one word in flight, ack seen SYNC_STAGES edges late.
   bit               m_busy = 1'b0;
   bit               m_req  = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   bit               m_done = 1'b0;
   bit               m_to   = 1'b0;
   int               m_wait = 0;
   bit               ack_hist [SYNC_STAGES];

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_busy = 1'b0;
         m_req  = 1'b0;
         m_data = '0;
         m_done = 1'b0;
         m_to   = 1'b0;
         m_wait = 0;
         for (int i = 0; i < SYNC_STAGES; i++) ack_hist[i] = 1'b0;
      end else begin
         bit seen;
         seen   = ack_hist[SYNC_STAGES-1];
         m_done = 1'b0;
         if (!m_busy) begin
            if (enq__ENA && (seen == m_req)) begin
               m_busy = 1'b1;
               m_req  = !m_req;
               m_data = enq_v;
               m_wait = 0;
            end
         end else begin
            m_wait++;
            if (TO_EN && m_wait >= TIMEOUT) m_to = 1'b1;
            if (seen == m_req) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end
         for (int i = SYNC_STAGES - 1; i > 0; i--) ack_hist[i] = ack_hist[i-1];
         ack_hist[0] = xfer_ack;
      end
   end

   always @(negedge CLK) begin
      if (run) begin
         chk("model_rdy",  enq__RDY,  (!m_busy && (ack_hist[SYNC_STAGES-1] == m_req)));
         chk("model_req",  xfer_req,  m_req);
         chk("model_data", xfer_data, m_data);
         chk("model_done", done,      m_done);
         chk("model_to",   timeout,   m_to);
         if (done) done_cnt++;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 20) begin
         step();
         n++;
      end
      if (!done) chk("done_wait_expired", 0, 1);
   endtask

   task automatic wait_rdy();
      int n;
      n = 0;
      while (!enq__RDY && n < 20) begin
         step();
         n++;
      end
      if (!enq__RDY) chk("rdy_wait_expired", 0, 1);
   endtask

   logic [WIDTH-1:0] words [4];
   int               base;

   initial begin
      words[0] = 32'hA5A5_0001;
      words[1] = 32'h0000_FFFF;
      words[2] = 32'hCAFE_F00D;
      words[3] = 32'h1357_9BDF;
      nRST     = 1'b0;
      enq__ENA = 1'b0;
      enq_v    = '0;
      xfer_ack = 1'b0;
      repeat (3) step();
      nRST = 1'b1;
      run  = 1'b1;
      step();

      // Reset state
      chk("reset_rdy",  enq__RDY,  1);
      chk("reset_req",  xfer_req,  0);
      chk("reset_data", xfer_data, 0);
      chk("reset_done", done,      0);
      chk("reset_to",   timeout,   0);

      // Single transfer, ack toggled before edge 5
      enq__ENA = 1'b1;
      enq_v    = 32'hDEAD_BEEF;
      step();                                    // edge 0
      enq__ENA = 1'b0;
      chk("enq_req",  xfer_req,  1);
      chk("enq_data", xfer_data, 32'hDEAD_BEEF);
      chk("enq_rdy",  enq__RDY,  0);
      step();                                    // edge 1
      enq__ENA = 1'b1;                           // ignored while busy
      enq_v    = 32'h1234_5678;
      step();                                    // edge 2
      enq__ENA = 1'b0;
      chk("ign_data", xfer_data, 32'hDEAD_BEEF);
      chk("ign_req",  xfer_req,  1);
      step();                                    // edge 3
      step();                                    // edge 4
      xfer_ack = 1'b1;
      step();                                    // edge 5
      step();                                    // edge 6
      chk("e6_done", done,     0);
      chk("e6_rdy",  enq__RDY, 0);
      step();                                    // edge 7
      chk("e7_done", done,      1);
      chk("e7_rdy",  enq__RDY,  1);
      chk("e7_data", xfer_data, 32'hDEAD_BEEF);
      step();
      chk("e8_done", done, 0);

      // Asynchronous reset mid-WAIT, destination reset together
      enq__ENA = 1'b1;
      enq_v    = 32'h0BAD_CAFE;
      step();
      enq__ENA = 1'b0;
      step();
      #2;
      nRST     = 1'b0;
      xfer_ack = 1'b0;
      #1;
      chk("arst_req",  xfer_req,  0);
      chk("arst_data", xfer_data, 0);
      chk("arst_done", done,      0);
      chk("arst_rdy",  enq__RDY,  1);
      step();
      step();
      nRST = 1'b1;
      step();

      // Back-to-back with 3-cycle destination echo
      base = done_cnt;
      for (int k = 0; k < 4; k++) begin
         wait_rdy();
         enq__ENA = 1'b1;
         enq_v    = words[k];
         step();
         enq__ENA = 1'b0;
         chk("b2b_req",  xfer_req,  (k % 2 == 0) ? 64'd1 : 64'd0);
         chk("b2b_data", xfer_data, words[k]);
         repeat (3) step();
         chk("b2b_hold", xfer_data, words[k]);
         xfer_ack = ~xfer_ack;
         wait_done();
      end
      step();
      chk("b2b_done_count", done_cnt - base, 4);
      chk("b2b_final_req",  xfer_req,        0);

      // Spurious ack toggle in IDLE
      xfer_ack = 1'b1;
      step();
      chk("spur_rdy1", enq__RDY, 1);
      step();
      chk("spur_rdy2", enq__RDY, 0);
      repeat (3) step();
      xfer_ack = 1'b0;
      step();
      step();
      chk("spur_back", enq__RDY, 1);

      // Timeout: no ack for TIMEOUT wait cycles
      enq__ENA = 1'b1;
      enq_v    = 32'h7777_0000;
      step();                                    // edge 0
      enq__ENA = 1'b0;
      repeat (TIMEOUT - 1) step();               // edge 15
      chk("to_before", timeout, 0);
      step();                                    // edge 16
      chk("to_set", timeout, TO_EN);
      repeat (3) step();
      chk("to_sticky", timeout, TO_EN);
      xfer_ack = 1'b1;
      wait_done();
      chk("to_late_done", done,    1);
      chk("to_after",     timeout, TO_EN);
      step();
      #2;
      nRST = 1'b0;
      xfer_ack = 1'b0;
      #1;
      chk("to_cleared", timeout, 0);
      step();
      nRST = 1'b1;
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
